// File: rtl/icache.sv
// Read-only 2-way set-associative instruction cache returning whole 128-bit lines.
// Hits are combinational in IDLE; a miss stalls fetch while one line is refilled.
module icache #(
    parameter int NUM_SETS   = 64,
    parameter int LINE_BYTES = 16,
    parameter int TAG_W      = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  paddr,
    input  logic         req,
    output logic [127:0] rdata_line,
    output logic         valid_out,
    output logic         stall_cpu,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MISS = 1'b1;

    logic               state_q, state_d;
    logic [TAG_W-1:0]   line_tag_q, line_tag_d;
    logic [IDX_W-1:0]   line_idx_q, line_idx_d;

    logic [NUM_SETS-1:0] valid_q [2];
    logic [NUM_SETS-1:0] lru_q;
    logic [TAG_W-1:0]    tag_mem  [2][NUM_SETS];
    logic [127:0]        data_mem [2][NUM_SETS];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         way_hit;
    logic               lookup_en;
    logic               hit;
    logic               hit_way;
    logic               fill_en;
    logic               victim;
    logic               unused_off;

    assign idx        = paddr[OFF_W +: IDX_W];
    assign tag        = paddr[OFF_W+IDX_W +: TAG_W];
    assign unused_off = ^paddr[OFF_W-1:0];

    // Outputs are forced quiet while rst is held so the reset values show immediately.
    assign lookup_en = (state_q == ST_IDLE) && req && !rst;
    assign hit       = lookup_en && (|way_hit);
    assign hit_way   = !way_hit[0];
    assign fill_en   = (state_q == ST_MISS) && mem_ready;

    // Fill an empty way first (way0 before way1); otherwise the LRU bit names the victim.
    assign victim = !valid_q[0][line_idx_q] ? 1'b0 :
                    !valid_q[1][line_idx_q] ? 1'b1 : lru_q[line_idx_q];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign way_hit[gi] = valid_q[gi][idx] && (tag_mem[gi][idx] == tag);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q[gi] <= '0;
                end else if (fill_en && (victim == 1'(gi))) begin
                    valid_q[gi][line_idx_q] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (fill_en && (victim == 1'(gi))) begin
                    tag_mem[gi][line_idx_q]  <= line_tag_q;
                    data_mem[gi][line_idx_q] <= mem_rdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_q <= '0;
        end else if (fill_en) begin
            lru_q[line_idx_q] <= ~victim;
        end else if (hit) begin
            lru_q[idx] <= ~hit_way;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_tag_d = line_tag_q;
        line_idx_d = line_idx_q;
        if (state_q == ST_IDLE) begin
            if (lookup_en && !hit) begin
                state_d    = ST_MISS;
                line_tag_d = tag;
                line_idx_d = idx;
            end
        end else if (mem_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            line_tag_q <= '0;
            line_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            line_tag_q <= line_tag_d;
            line_idx_q <= line_idx_d;
        end
    end

    assign valid_out  = hit;
    assign rdata_line = hit ? data_mem[hit_way][idx] : '0;
    assign stall_cpu  = (state_q == ST_MISS) || (lookup_en && !hit);
    assign mem_req    = (state_q == ST_MISS);
    assign mem_addr   = (state_q == ST_MISS) ? {line_tag_q, line_idx_q, {OFF_W{1'b0}}} : '0;
    assign mem_we     = 1'b0;
    assign mem_wdata  = '0;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: one-cycle vector table plus hand sequences for
// delayed grant, req dropped mid-miss and reset mid-miss.
module tb_icache;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  paddr;
    logic         req;
    logic [127:0] rdata_line;
    logic         valid_out;
    logic         stall_cpu;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int errors = 0;
    int checks = 0;

    icache dut (
        .clk        (clk),
        .rst        (rst),
        .paddr      (paddr),
        .req        (req),
        .rdata_line (rdata_line),
        .valid_out  (valid_out),
        .stall_cpu  (stall_cpu),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  paddr;
        logic         req;
        logic         rdy;
        logic [127:0] mdata;
        logic         e_valid;
        logic         e_stall;
        logic         e_mreq;
        logic [31:0]  e_maddr;
        logic [127:0] e_rdata;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    localparam logic [127:0] L0  = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
    localparam logic [127:0] LA  = 128'h44444444_00000000_AAAAAAAA_11111111;
    localparam logic [127:0] LB  = 128'h88888888_BBBBBBBB_22222222_33333333;
    localparam logic [127:0] LA2 = 128'h40404040_A2A2A2A2_55555555_66666666;
    localparam logic [127:0] LJ  = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    localparam logic [127:0] L2  = 128'h02000200_12345678_9ABCDEF0_0F0F0F0F;
    localparam logic [127:0] L3  = 128'h03100310_13579BDF_2468ACE0_A5A5A5A5;
    localparam logic [127:0] L5  = 128'h05200520_FEDCBA98_76543210_5A5A5A5A;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic es, input logic em,
                             input logic [31:0] ea, input logic [127:0] ed);
        check({tag, " valid_out"},  128'(valid_out),  128'(ev));
        check({tag, " stall_cpu"},  128'(stall_cpu),  128'(es));
        check({tag, " mem_req"},    128'(mem_req),    128'(em));
        check({tag, " mem_addr"},   128'(mem_addr),   128'(ea));
        check({tag, " rdata_line"}, rdata_line,       ed);
        check({tag, " mem_we"},     128'(mem_we),     128'(0));
        check({tag, " mem_wdata"},  mem_wdata,        128'(0));
    endtask

    initial begin
        // cold miss, same-line hit, 0x400 fill
        vecs[0]  = '{32'h000, 1'b0, 1'b0, '0,  1'b0, 1'b0, 1'b0, 32'h000, '0};
        vecs[1]  = '{32'h000, 1'b1, 1'b0, '0,  1'b0, 1'b1, 1'b0, 32'h000, '0};
        vecs[2]  = '{32'h000, 1'b1, 1'b1, L0,  1'b0, 1'b1, 1'b1, 32'h000, '0};
        vecs[3]  = '{32'h004, 1'b1, 1'b0, '0,  1'b1, 1'b0, 1'b0, 32'h000, L0};
        vecs[4]  = '{32'h400, 1'b1, 1'b0, '0,  1'b0, 1'b1, 1'b0, 32'h000, '0};
        vecs[5]  = '{32'h400, 1'b1, 1'b1, LA,  1'b0, 1'b1, 1'b1, 32'h400, '0};
        vecs[6]  = '{32'h408, 1'b1, 1'b0, '0,  1'b1, 1'b0, 1'b0, 32'h000, LA};
        // re-hit 0x000 makes 0x400's way the LRU victim for 0x800
        vecs[7]  = '{32'h000, 1'b1, 1'b0, '0,  1'b1, 1'b0, 1'b0, 32'h000, L0};
        vecs[8]  = '{32'h800, 1'b1, 1'b0, '0,  1'b0, 1'b1, 1'b0, 32'h000, '0};
        vecs[9]  = '{32'h800, 1'b1, 1'b1, LB,  1'b0, 1'b1, 1'b1, 32'h800, '0};
        vecs[10] = '{32'h800, 1'b1, 1'b0, '0,  1'b1, 1'b0, 1'b0, 32'h000, LB};
        vecs[11] = '{32'h00C, 1'b1, 1'b0, '0,  1'b1, 1'b0, 1'b0, 32'h000, L0};
        // stray mem_ready in IDLE is ignored
        vecs[12] = '{32'h000, 1'b0, 1'b1, LJ,  1'b0, 1'b0, 1'b0, 32'h000, '0};
        vecs[13] = '{32'h400, 1'b1, 1'b0, '0,  1'b0, 1'b1, 1'b0, 32'h000, '0};
        vecs[14] = '{32'h400, 1'b1, 1'b1, LA2, 1'b0, 1'b1, 1'b1, 32'h400, '0};
        vecs[15] = '{32'h400, 1'b1, 1'b0, '0,  1'b1, 1'b0, 1'b0, 32'h000, LA2};
        vecs[16] = '{32'h000, 1'b1, 1'b0, '0,  1'b1, 1'b0, 1'b0, 32'h000, L0};

        rst = 1'b1; paddr = '0; req = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
        #2;
        check_all("reset", 1'b0, 1'b0, 1'b0, 32'h0, '0);
        cyc();
        rst = 1'b0;
        cyc();

        for (int i = 0; i < NV; i++) begin
            paddr = vecs[i].paddr; req = vecs[i].req;
            mem_ready = vecs[i].rdy; mem_rdata = vecs[i].mdata;
            #1;
            $display("vec %0d paddr=%h req=%b rdy=%b -> valid=%b stall=%b mreq=%b maddr=%h",
                     i, paddr, req, mem_ready, valid_out, stall_cpu, mem_req, mem_addr);
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_stall,
                      vecs[i].e_mreq, vecs[i].e_maddr, vecs[i].e_rdata);
            cyc();
        end
        mem_ready = 1'b0; mem_rdata = '0;

        // delayed grant at 0x200
        paddr = 32'h200; req = 1'b1; #1;
        check_all("dly detect", 1'b0, 1'b1, 1'b0, 32'h0, '0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("dly%0d mem_req", i),   128'(mem_req),   128'(1));
            check($sformatf("dly%0d mem_addr", i),  128'(mem_addr),  128'(32'h200));
            check($sformatf("dly%0d stall_cpu", i), 128'(stall_cpu), 128'(1));
            cyc();
        end
        mem_ready = 1'b1; mem_rdata = L2; #1;
        check_all("dly grant", 1'b0, 1'b1, 1'b1, 32'h200, '0);
        cyc();
        mem_ready = 1'b0; mem_rdata = '0; #1;
        check_all("dly hit", 1'b1, 1'b0, 1'b0, 32'h0, L2);
        $display("delayed grant done valid=%b rdata=%h", valid_out, rdata_line);
        cyc();

        // req dropped mid-miss at 0x310
        paddr = 32'h310; req = 1'b1; #1;
        check_all("drop detect", 1'b0, 1'b1, 1'b0, 32'h0, '0);
        cyc();
        req = 1'b0; paddr = 32'h0; #1;
        check_all("drop miss", 1'b0, 1'b1, 1'b1, 32'h310, '0);
        cyc();
        mem_ready = 1'b1; mem_rdata = L3; #1;
        check_all("drop ready", 1'b0, 1'b1, 1'b1, 32'h310, '0);
        cyc();
        mem_ready = 1'b0; mem_rdata = '0; #1;
        check_all("drop idle", 1'b0, 1'b0, 1'b0, 32'h0, '0);
        cyc();
        paddr = 32'h318; req = 1'b1; #1;
        check_all("drop rehit", 1'b1, 1'b0, 1'b0, 32'h0, L3);
        $display("req-drop done valid=%b rdata=%h", valid_out, rdata_line);
        cyc();

        // reset mid-miss at 0x520
        paddr = 32'h520; req = 1'b1; #1;
        check_all("rst detect", 1'b0, 1'b1, 1'b0, 32'h0, '0);
        cyc();
        #1;
        check_all("rst miss", 1'b0, 1'b1, 1'b1, 32'h520, '0);
        rst = 1'b1; #1;
        check_all("rst held", 1'b0, 1'b0, 1'b0, 32'h0, '0);
        cyc();
        rst = 1'b0; #1;
        check_all("rst remiss", 1'b0, 1'b1, 1'b0, 32'h0, '0);
        cyc();
        #1;
        check_all("rst refill", 1'b0, 1'b1, 1'b1, 32'h520, '0);
        mem_ready = 1'b1; mem_rdata = L5;
        cyc();
        mem_ready = 1'b0; mem_rdata = '0; #1;
        check_all("rst hit", 1'b1, 1'b0, 1'b0, 32'h0, L5);
        // reset cleared everything, so an earlier line must miss again
        paddr = 32'h000; #1;
        check_all("rst cold", 1'b0, 1'b1, 1'b0, 32'h0, '0);
        $display("reset mid-miss done stall=%b mem_req=%b", stall_cpu, mem_req);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
